// File: rtl/nios_led_out_pio.sv
// nios_led_out_pio: Avalon-MM output PIO for board LEDs.
// A data register drives out_port. OUTSET and OUTCLEAR give atomic bit set
// and clear. A per-bit blink engine masks selected bits on alternate
// half-periods, so software never has to toggle LEDs itself.
// All outputs are registered, and readdata has one cycle of read latency.
module nios_led_out_pio #(
  parameter int WIDTH    = 10,
  parameter int PERIOD_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

  logic                wr_s;
  logic [WIDTH-1:0]    wd_s;

  logic [WIDTH-1:0]    data_q,     data_d;
  logic [WIDTH-1:0]    mask_q,     mask_d;
  logic [PERIOD_W-1:0] period_q,   period_d;
  logic [PERIOD_W-1:0] cnt_q,      cnt_d;
  logic                phase_q,    phase_d;
  logic [WIDTH-1:0]    out_port_q, out_port_d;
  logic [31:0]         readdata_q, readdata_d;

  logic [PERIOD_W-1:0] cnt_run_s;
  logic                phase_run_s;

  assign wr_s = chipselect & ~write_n;
  assign wd_s = writedata[WIDTH-1:0];

  // Register file updates: plain writes and the atomic set/clear on DATA.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_s) begin
      case (address)
        ADDR_DATA:     data_d   = wd_s;
        ADDR_MASK:     mask_d   = wd_s;
        ADDR_PERIOD:   period_d = writedata[PERIOD_W-1:0];
        ADDR_OUTSET:   data_d   = data_q | wd_s;
        ADDR_OUTCLEAR: data_d   = data_q & ~wd_s;
        default: begin
          data_d   = data_q;
          mask_d   = mask_q;
          period_d = period_q;
        end
      endcase
    end else begin
      data_d   = data_q;
      mask_d   = mask_q;
      period_d = period_q;
    end
  end

  // Free-running blink engine: counts one half-period and then flips the phase.
  always_comb begin
    cnt_run_s   = cnt_q;
    phase_run_s = phase_q;
    if (period_q == {PERIOD_W{1'b0}}) begin
      cnt_run_s   = {PERIOD_W{1'b0}};
      phase_run_s = phase_q;
    end else if (cnt_q == (period_q - PERIOD_ONE)) begin
      cnt_run_s   = {PERIOD_W{1'b0}};
      phase_run_s = ~phase_q;
    end else begin
      cnt_run_s   = cnt_q + PERIOD_ONE;
      phase_run_s = phase_q;
    end
  end

  // Writes to PERIOD/STATUS restart the engine and take priority over a terminal-count toggle.
  always_comb begin
    cnt_d   = cnt_run_s;
    phase_d = phase_run_s;
    if (wr_s) begin
      case (address)
        ADDR_PERIOD: begin
          cnt_d   = {PERIOD_W{1'b0}};
          phase_d = phase_q;
        end
        ADDR_STATUS: begin
          cnt_d   = {PERIOD_W{1'b0}};
          phase_d = 1'b0;
        end
        default: begin
          cnt_d   = cnt_run_s;
          phase_d = phase_run_s;
        end
      endcase
    end else begin
      cnt_d   = cnt_run_s;
      phase_d = phase_run_s;
    end
  end

  // Read mux on pre-write state; unmapped and write-only addresses read as zero.
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      ADDR_DATA:   readdata_d[WIDTH-1:0]    = data_q;
      ADDR_MASK:   readdata_d[WIDTH-1:0]    = mask_q;
      ADDR_PERIOD: readdata_d[PERIOD_W-1:0] = period_q;
      ADDR_STATUS: readdata_d[0]            = phase_q;
      default:     readdata_d               = 32'd0;
    endcase
  end

  // LED drive: a blinking bit is forced off while the phase is high.
  always_comb begin
    out_port_d = data_q & ~(mask_q & {WIDTH{phase_q}});
  end

  // State registers with synchronous reset; reset overrides any coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= {WIDTH{1'b0}};
      mask_q     <= {WIDTH{1'b0}};
      period_q   <= {PERIOD_W{1'b0}};
      cnt_q      <= {PERIOD_W{1'b0}};
      phase_q    <= 1'b0;
      out_port_q <= {WIDTH{1'b0}};
      readdata_q <= 32'd0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      out_port_q <= out_port_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_port_q;

endmodule
